alu_uart_ctrl: RTL

- Sequencer between a UART receiver/transmitter pair and the combinational ALU.
- Collects three received bytes in order (operand A, operand B, opcode) and drives the registered operands onto the ALU.
- Captures the ALU result one cycle later and hands it to the transmitter with a start/done handshake.
- Replaces the three-button load scheme for board builds driven from a host PC.

---
 rtl/alu_uart_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/alu_uart_ctrl.sv
// Sequences UART bytes (A, B, opcode) into ALU operands, returns the result.
// Ports: clock/reset_n, rx_done/rx_data in, alu_result in, tx_done in;
//   alu_a/alu_b/alu_op, tx_data/tx_start, busy, frame_error, overrun out.
module alu_uart_ctrl #(
   parameter int          N_BITS      = 8,
   parameter int          N_OP        = 6,
   parameter int unsigned TIMEOUT_CYC = 50000000
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              rx_done,
   input  logic [N_BITS-1:0] rx_data,
   input  logic [N_BITS-1:0] alu_result,
   input  logic              tx_done,
   output logic [N_BITS-1:0] alu_a,
   output logic [N_BITS-1:0] alu_b,
   output logic [N_OP-1:0]   alu_op,
   output logic [N_BITS-1:0] tx_data,
   output logic              tx_start,
   output logic              busy,
   output logic              frame_error,
   output logic              overrun
);

   typedef enum logic [2:0] {
      S_WAIT_A,
      S_WAIT_B,
      S_WAIT_OP,
      S_EXEC,
      S_SEND,
      S_WAIT_TX
   } state_t;

   localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CW-1:0] TMO_LAST =
      CW'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

   state_t        state;
   state_t        state_n;
   logic [CW-1:0] tmo_cnt;
   logic [CW-1:0] cnt_n;
   logic          tmo_hit;
   logic          expire;
   logic          ld_a;
   logic          ld_b;
   logic          ld_op;
   logic          ld_tx;
   logic          busy_n;
   logic          start_n;
   logic          ovr_n;

   assign tmo_hit = (TIMEOUT_CYC != 0) && (tmo_cnt == TMO_LAST);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= S_WAIT_A;
      else          state <= state_n;
   end

   // A byte arriving in the expiry cycle wins over the timeout.
   always_comb begin
      state_n = state;
      expire  = 1'b0;
      unique case (state)
         S_WAIT_A:
            if (rx_done) state_n = S_WAIT_B;
         S_WAIT_B:
            if (rx_done) state_n = S_WAIT_OP;
            else if (tmo_hit) begin
               state_n = S_WAIT_A;
               expire  = 1'b1;
            end
         S_WAIT_OP:
            if (rx_done) state_n = S_EXEC;
            else if (tmo_hit) begin
               state_n = S_WAIT_A;
               expire  = 1'b1;
            end
         S_EXEC:    state_n = S_SEND;
         S_SEND:    state_n = S_WAIT_TX;
         S_WAIT_TX:
            if (tx_done) state_n = S_WAIT_A;
         default:   state_n = S_WAIT_A;
      endcase
   end

   // Flags are computed from the next state so the registered copies
   // line up exactly with the state they describe.
   always_comb begin
      ld_a    = (state == S_WAIT_A)  && rx_done;
      ld_b    = (state == S_WAIT_B)  && rx_done;
      ld_op   = (state == S_WAIT_OP) && rx_done;
      ld_tx   = (state == S_EXEC);
      busy_n  = (state_n == S_EXEC) || (state_n == S_SEND) ||
                (state_n == S_WAIT_TX);
      start_n = (state_n == S_SEND);
      ovr_n   = rx_done && busy;
      cnt_n   = '0;
      if ((TIMEOUT_CYC != 0) && (state_n == state) &&
          ((state == S_WAIT_B) || (state == S_WAIT_OP)))
         cnt_n = tmo_cnt + 1'b1;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         alu_a       <= '0;
         alu_b       <= '0;
         alu_op      <= '0;
         tx_data     <= '0;
         tx_start    <= 1'b0;
         busy        <= 1'b0;
         frame_error <= 1'b0;
         overrun     <= 1'b0;
         tmo_cnt     <= '0;
      end else begin
         if (ld_a)  alu_a   <= rx_data;
         if (ld_b)  alu_b   <= rx_data;
         if (ld_op) alu_op  <= rx_data[N_OP-1:0];
         if (ld_tx) tx_data <= alu_result;
         tx_start    <= start_n;
         busy        <= busy_n;
         frame_error <= expire;
         overrun     <= ovr_n;
         tmo_cnt     <= cnt_n;
      end
   end

endmodule
